// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin request/grant responder with a registered one-hot
// grant, a one-cycle dead gap between owners and optional max-hold preemption.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no grant; next requester chosen from ptr upward, wrapping
// GRANTED | owner holds grant until it drops request or is preempted
module rr_arbiter #(
  parameter int N        = 2,
  parameter int MAX_HOLD = 4,
  localparam int OW      = (N > 1) ? $clog2(N) : 1,
  localparam int HW      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  request,
  output logic [N-1:0]  grant,
  output logic          busy,
  output logic [OW-1:0] owner
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] GRANTED = 1'b1;

  // With preemption disabled the counter simply parks at all-ones.
  localparam logic [HW-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {HW{1'b1}} : HW'(MAX_HOLD);

  logic [0:0]    state;
  logic [OW-1:0] ptr;
  logic [HW-1:0] hold_cnt;

  logic          found;
  logic [OW-1:0] win;
  logic [N-1:0]  win_oh;
  logic [OW-1:0] ptr_next;
  logic          others_req;
  logic          preempt;

  // Winner search: lowest set bit at or above ptr, else lowest set bit below ptr.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int j = 0; j < N; j++) begin
      if (!found && request[j] && (j >= int'(ptr))) begin
        found = 1'b1;
        win   = OW'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && request[j] && (j < int'(ptr))) begin
        found = 1'b1;
        win   = OW'(j);
      end
    end
  end

  // One-hot form of the winner for loading the grant register.
  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  // Release bookkeeping: next pointer and preemption condition.
  always_comb begin
    ptr_next   = (owner == OW'(N - 1)) ? '0 : owner + OW'(1);
    others_req = |(request & ~grant);
    preempt    = (MAX_HOLD != 0) && (hold_cnt == HOLD_SAT) && others_req;
  end

  // Arbitration FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      busy     <= 1'b0;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant    <= win_oh;
            owner    <= win;
            busy     <= 1'b1;
            hold_cnt <= HW'(1);
            state    <= GRANTED;
          end
        end
        GRANTED: begin
          // Release always passes through IDLE so grants never overlap.
          if (!request[owner] || preempt) begin
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= ptr_next;
            state <= IDLE;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed vectors for the N=2, MAX_HOLD=4 arbiter plus
// continuously checked grant invariants.
module tb_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] request;
  logic [1:0] grant;
  logic       busy;
  logic [0:0] owner;

  int checks   = 0;
  int failures = 0;

  logic [1:0] req_q;
  logic [1:0] grant_prev;
  logic       inv_en;

  rr_arbiter #(.N(2), .MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .request (request),
    .grant   (grant),
    .busy    (busy),
    .owner   (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check grant/busy, and owner whenever a grant is expected.
  task automatic expect_g(input string tag, input logic [1:0] g);
    check_eq({tag, "_grant"}, 32'(grant), 32'(g));
    check_eq({tag, "_busy"}, 32'(busy), 32'(|g));
    if (g == 2'b01) check_eq({tag, "_owner"}, 32'(owner), 32'd0);
    if (g == 2'b10) check_eq({tag, "_owner"}, 32'(owner), 32'd1);
  endtask

  // Request value present at each rising edge, for the rise rule.
  always @(posedge clk) req_q <= request;

  // Invariants, checked mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (inv_en) begin
      check_eq("inv_onehot", 32'($onehot0(grant)), 32'd1);
      check_eq("inv_busy", 32'(busy), 32'(|grant));
      if (busy) check_eq("inv_owner", 32'(grant[owner]), 32'd1);
      check_eq("inv_rise", 32'(grant & ~grant_prev & ~req_q), 32'd0);
    end
    grant_prev = grant;
  end

  initial begin
    logic [1:0] rot_seq [14];
    rot_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                2'b10, 2'b10, 2'b10, 2'b10, 2'b00,
                2'b01, 2'b01, 2'b01, 2'b01};
    inv_en     = 1'b0;
    grant_prev = 2'b00;
    req_q      = 2'b00;
    rst        = 1'b1;
    request    = 2'b11;

    // 1. Reset held two edges with both requesting.
    step();
    expect_g("rst_e1", 2'b00);
    step();
    expect_g("rst_e2", 2'b00);
    inv_en = 1'b1;
    rst    = 1'b0;

    // 3. Preemption rotation from reset release (first entry covers item 1).
    for (int i = 0; i < 14; i++) begin
      step();
      expect_g($sformatf("rot%0d", i), rot_seq[i]);
    end

    // 2. Single request, drop, then requester 0.
    rst     = 1'b1;
    request = 2'b00;
    step();
    rst     = 1'b0;
    request = 2'b10;
    step();
    expect_g("single_t", 2'b10);
    step();
    expect_g("single_t1", 2'b10);
    step();
    expect_g("single_t2", 2'b10);
    request = 2'b00;
    step();
    expect_g("single_drop", 2'b00);
    request = 2'b01;
    step();
    expect_g("single_wrap", 2'b01);

    // 4. Voluntary release by requester 0 after two cycles.
    rst     = 1'b1;
    request = 2'b11;
    step();
    rst = 1'b0;
    step();
    expect_g("vol_c1", 2'b01);
    step();
    expect_g("vol_c2", 2'b01);
    request = 2'b10;
    step();
    expect_g("vol_gap", 2'b00);
    step();
    expect_g("vol_r1_1", 2'b10);
    step();
    expect_g("vol_r1_2", 2'b10);
    step();
    expect_g("vol_r1_3", 2'b10);
    request = 2'b11;
    step();
    expect_g("vol_r1_4", 2'b10);
    step();
    expect_g("vol_preempt", 2'b00);
    step();
    expect_g("vol_back0", 2'b01);

    // 5. Solo hold never preempts; late contender takes over after a gap.
    rst     = 1'b1;
    request = 2'b01;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      expect_g($sformatf("solo%0d", i), 2'b01);
    end
    request = 2'b11;
    step();
    expect_g("late_gap", 2'b00);
    step();
    expect_g("late_r1", 2'b10);

    // 6. Reset mid-grant restores ptr to 0.
    rst = 1'b1;
    step();
    expect_g("midrst", 2'b00);
    rst = 1'b0;
    step();
    expect_g("midrst_ptr0", 2'b01);
    step();

    inv_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
